// File: rtl/axi4_lite_master_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM state encoding,
// and response-to-error mapping used by the master and the slave interface.
package axi4_lite_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned STRB_BITS = DATA_BITS / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } axil_state_t;

    // Only the slave-side error codes flag a failed transfer.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        unique case (resp)
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a simple command/response port
// into AW/W/B or AR/R transactions. All AXI outputs come straight from flops.
module axi4_lite_master
    import axi4_lite_master_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cmd_valid,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_wstrb,
    output logic                 cmd_ready,

    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,

    output logic [ADDR_BITS-1:0] m_axi_awaddr,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [31:0]          m_axi_wdata,
    output logic [3:0]           m_axi_wstrb,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [ADDR_BITS-1:0] m_axi_araddr,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [31:0]          m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
);

    axil_state_t state, state_next;

    logic                 aw_done, aw_done_next;
    logic                 w_done, w_done_next;
    logic                 awvalid_q, awvalid_next;
    logic                 wvalid_q, wvalid_next;
    logic                 bready_q, bready_next;
    logic                 arvalid_q, arvalid_next;
    logic                 rready_q, rready_next;
    logic                 rsp_valid_q, rsp_valid_next;
    logic                 rsp_err_q, rsp_err_next;
    logic [31:0]          rsp_rdata_q, rsp_rdata_next;
    logic [ADDR_BITS-1:0] addr_q, addr_next;
    logic [31:0]          wdata_q, wdata_next;
    logic [3:0]           wstrb_q, wstrb_next;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid_q && m_axi_awready;
    assign w_hs  = wvalid_q && m_axi_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state       <= state_next;
            aw_done     <= aw_done_next;
            w_done      <= w_done_next;
            awvalid_q   <= awvalid_next;
            wvalid_q    <= wvalid_next;
            bready_q    <= bready_next;
            arvalid_q   <= arvalid_next;
            rready_q    <= rready_next;
            rsp_valid_q <= rsp_valid_next;
            rsp_err_q   <= rsp_err_next;
            rsp_rdata_q <= rsp_rdata_next;
            addr_q      <= addr_next;
            wdata_q     <= wdata_next;
            wstrb_q     <= wstrb_next;
        end
    end

    // Registered outputs are computed one cycle ahead alongside the next state,
    // so every AXI signal leaves the block from a flop.
    always_comb begin
        state_next     = state;
        aw_done_next   = aw_done;
        w_done_next    = w_done;
        awvalid_next   = awvalid_q;
        wvalid_next    = wvalid_q;
        bready_next    = bready_q;
        arvalid_next   = arvalid_q;
        rready_next    = rready_q;
        rsp_valid_next = 1'b0;
        rsp_err_next   = rsp_err_q;
        rsp_rdata_next = rsp_rdata_q;
        addr_next      = addr_q;
        wdata_next     = wdata_q;
        wstrb_next     = wstrb_q;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_next = cmd_addr;
                    if (cmd_write) begin
                        wdata_next   = cmd_wdata;
                        wstrb_next   = cmd_wstrb;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR_REQ;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                // AW and W complete independently; leave once both have.
                aw_done_next = aw_done || aw_hs;
                w_done_next  = w_done || w_hs;
                if (aw_hs) awvalid_next = 1'b0;
                if (w_hs)  wvalid_next  = 1'b0;
                if (aw_done_next && w_done_next) begin
                    bready_next = 1'b1;
                    state_next  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = resp_is_err(m_axi_bresp);
                    state_next     = IDLE;
                end
            end

            RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_RESP;
                end
            end

            RD_RESP: begin
                if (m_axi_rvalid) begin
                    rready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = resp_is_err(m_axi_rresp);
                    rsp_rdata_next = m_axi_rdata;
                    state_next     = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready     = (state == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed self-checking bench for axi4_lite_master; the bench plays the slave
// and checks each cycle against hand-computed expectations.
module tb_axi4_lite_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [3:0]  m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int unsigned n_cmp;
    int unsigned n_bad;

    axi4_lite_master #(.ADDR_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %0h want 1", cmd_ready); end
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
            n_bad++; $display("FAIL rst_axi_valids: got %b want 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %0h want 0", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_err: got %0h want 0", rsp_err); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h want 00000000", rsp_rdata); end
        n_cmp++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== 40'h0) begin
            n_bad++; $display("FAIL rst_addr_data: got %h want 0", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}); end
        rst = 1'b0;
    endtask

    task automatic test_write_basic;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        tick();  // cycle 1
        cmd_valid = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin n_bad++; $display("FAIL wr_c1_valids: got %b want 11", {m_axi_awvalid, m_axi_wvalid}); end
        n_cmp++; if (m_axi_awaddr !== 4'h4) begin n_bad++; $display("FAIL wr_c1_awaddr: got %h want 4", m_axi_awaddr); end
        n_cmp++; if (m_axi_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_c1_wdata: got %h want deadbeef", m_axi_wdata); end
        n_cmp++; if (m_axi_wstrb !== 4'hF) begin n_bad++; $display("FAIL wr_c1_wstrb: got %h want f", m_axi_wstrb); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL wr_c1_cmd_ready: got %0h want 0", cmd_ready); end
        tick();  // cycle 2
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
            n_bad++; $display("FAIL wr_c2_aw_w_b: got %b want 001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_c2_rsp_valid: got %0h want 0", rsp_valid); end
        tick();  // cycle 3
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL wr_c3_rsp_valid: got %0h want 1", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL wr_c3_rsp_err: got %0h want 0", rsp_err); end
        n_cmp++; if ({cmd_ready, m_axi_bready} !== 2'b10) begin n_bad++; $display("FAIL wr_c3_ready: got %b want 10", {cmd_ready, m_axi_bready}); end
        m_axi_bvalid = 1'b0;
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_c4_rsp_pulse: got %0h want 0", rsp_valid); end
    endtask

    task automatic test_write_err;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b11;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h2; cmd_wdata = 32'h0000_00FF; cmd_wstrb = 4'h1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL wr_decerr_rsp_valid: got %0h want 1", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL wr_decerr_rsp_err: got %0h want 1", rsp_err); end
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        tick();
    endtask

    task automatic test_write_aw_delay;
        int unsigned aw_cnt = 0;
        int unsigned w_cnt = 0;
        int unsigned rsp_cnt = 0;
        logic addr_stable = 1'b1;
        m_axi_awready = 1'b0; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h6; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'h3;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (m_axi_awvalid === 1'b1) begin
                aw_cnt++;
                if (m_axi_awaddr !== 4'h6) addr_stable = 1'b0;
            end
            if (m_axi_wvalid === 1'b1) w_cnt++;
            if (rsp_valid === 1'b1) begin rsp_cnt++; m_axi_bvalid = 1'b0; end
            if (m_axi_bready === 1'b1) m_axi_bvalid = 1'b1;
            m_axi_awready = (k == 4);
            tick();
        end
        m_axi_bvalid = 1'b0;
        n_cmp++; if (aw_cnt != 4) begin n_bad++; $display("FAIL awdly_awvalid_cycles: got %0d want 4", aw_cnt); end
        n_cmp++; if (w_cnt != 1) begin n_bad++; $display("FAIL awdly_wvalid_cycles: got %0d want 1", w_cnt); end
        n_cmp++; if (addr_stable !== 1'b1) begin n_bad++; $display("FAIL awdly_awaddr_stable: got %0h want 1", addr_stable); end
        n_cmp++; if (rsp_cnt != 1) begin n_bad++; $display("FAIL awdly_rsp_count: got %0d want 1", rsp_cnt); end
    endtask

    task automatic test_read_basic;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h000000A5; m_axi_rresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8;
        tick();  // cycle 1
        cmd_valid = 1'b0;
        n_cmp++; if (m_axi_arvalid !== 1'b1) begin n_bad++; $display("FAIL rd_c1_arvalid: got %0h want 1", m_axi_arvalid); end
        n_cmp++; if (m_axi_araddr !== 4'h8) begin n_bad++; $display("FAIL rd_c1_araddr: got %h want 8", m_axi_araddr); end
        n_cmp++; if (m_axi_rready !== 1'b0) begin n_bad++; $display("FAIL rd_c1_rready: got %0h want 0", m_axi_rready); end
        tick();  // cycle 2
        n_cmp++; if ({m_axi_arvalid, m_axi_rready} !== 2'b01) begin n_bad++; $display("FAIL rd_c2_ar_r: got %b want 01", {m_axi_arvalid, m_axi_rready}); end
        tick();  // cycle 3
        n_cmp++; if ({rsp_valid, m_axi_rready} !== 2'b01) begin n_bad++; $display("FAIL rd_c3_wait: got %b want 01", {rsp_valid, m_axi_rready}); end
        m_axi_rvalid = 1'b1;
        tick();  // cycle 4
        m_axi_rvalid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_c4_rsp_valid: got %0h want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h000000A5) begin n_bad++; $display("FAIL rd_c4_rsp_rdata: got %h want 000000a5", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_c4_rsp_err: got %0h want 0", rsp_err); end
        n_cmp++; if (m_axi_rready !== 1'b0) begin n_bad++; $display("FAIL rd_c4_rready: got %0h want 0", m_axi_rready); end
        tick();
    endtask

    task automatic test_read_err;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h12345678; m_axi_rresp = 2'b10;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hA;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        m_axi_rvalid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rderr_rsp_valid: got %0h want 1", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL rderr_rsp_err: got %0h want 1", rsp_err); end
        n_cmp++; if (rsp_rdata !== 32'h12345678) begin n_bad++; $display("FAIL rderr_rsp_rdata: got %h want 12345678", rsp_rdata); end
        m_axi_rresp = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'h11111111; cmd_wstrb = 4'hF;
        tick();  // cycle 1
        n_cmp++; if ({m_axi_awvalid, cmd_ready} !== 2'b10) begin n_bad++; $display("FAIL b2b_c1: got %b want 10", {m_axi_awvalid, cmd_ready}); end
        n_cmp++; if (m_axi_awaddr !== 4'hC) begin n_bad++; $display("FAIL b2b_c1_awaddr: got %h want c", m_axi_awaddr); end
        tick();  // cycle 2
        n_cmp++; if ({m_axi_awvalid, cmd_ready} !== 2'b00) begin n_bad++; $display("FAIL b2b_c2: got %b want 00", {m_axi_awvalid, cmd_ready}); end
        tick();  // cycle 3: response of first, second accepted at end of it
        n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b11) begin n_bad++; $display("FAIL b2b_c3: got %b want 11", {rsp_valid, cmd_ready}); end
        cmd_addr = 4'h4; cmd_wdata = 32'h22222222;
        tick();  // cycle 4
        cmd_valid = 1'b0;
        n_cmp++; if ({m_axi_awvalid, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL b2b_c4: got %b want 10", {m_axi_awvalid, rsp_valid}); end
        n_cmp++; if ({m_axi_awaddr, m_axi_wdata} !== {4'h4, 32'h22222222}) begin
            n_bad++; $display("FAIL b2b_c4_addr_data: got %h want 422222222", {m_axi_awaddr, m_axi_wdata}); end
        tick();
        tick();  // cycle 6
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_c6_rsp_valid: got %0h want 1", rsp_valid); end
        m_axi_bvalid = 1'b0;
        tick();
        n_cmp++; if ({cmd_ready, m_axi_awvalid, rsp_valid} !== 3'b100) begin
            n_bad++; $display("FAIL b2b_c7_idle: got %b want 100", {cmd_ready, m_axi_awvalid, rsp_valid}); end
        n_cmp++; if (rsp_rdata !== 32'h12345678) begin n_bad++; $display("FAIL b2b_rdata_held: got %h want 12345678", rsp_rdata); end
    endtask

    task automatic test_reset_mid;
        int unsigned rsp_cnt = 0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h1; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();  // in WR_RESP
        n_cmp++; if (m_axi_bready !== 1'b1) begin n_bad++; $display("FAIL rmid_bready_before: got %0h want 1", m_axi_bready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid} !== 6'b0) begin
            n_bad++; $display("FAIL rmid_valids: got %b want 000000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid}); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_cmd_ready: got %0h want 1", cmd_ready); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rmid_rsp_rdata: got %h want 00000000", rsp_rdata); end
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid === 1'b1) rsp_cnt++;
            tick();
        end
        n_cmp++; if (rsp_cnt != 0) begin n_bad++; $display("FAIL rmid_no_rsp: got %0d want 0", rsp_cnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;

        test_reset();
        test_write_basic();
        test_write_err();
        test_write_aw_delay();
        test_read_basic();
        test_read_err();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
